// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of the unified memory; one access in flight at a time.
// Optional feature macro ARB_LOCK_EN adds the l_lock input so the loader can keep the memory.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_ready,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic [DW-1:0] l_rdata,
    output logic          l_ready,
`ifdef ARB_LOCK_EN
    input  logic          l_lock,
`endif
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic [1:0]    grant
);

    localparam int unsigned CW = 4;
    localparam logic PORT_CORE   = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic          lock_q, lock_d;
    logic          pick;
    logic          lock_in;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;
    logic [DW-1:0] c_rdata_d, l_rdata_d;
    logic          m_en_d, m_we_d, c_ready_d, l_ready_d;
    logic [1:0]    grant_d;

`ifdef ARB_LOCK_EN
    assign lock_in = l_lock;
`else
    assign lock_in = 1'b0;
`endif

    // Next state, request latching, read capture and next registered outputs
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        we_d      = we_q;
        lock_d    = lock_q;
        cnt_d     = cnt_q;
        addr_d    = m_addr;
        wdata_d   = m_wdata;
        c_rdata_d = c_rdata;
        l_rdata_d = l_rdata;
        pick      = PORT_CORE;

        case (state_q)
            S_IDLE: begin
                if (lock_q && !l_req) begin
                    lock_d = 1'b0;
                end
                if (lock_q && l_req) begin
                    pick = PORT_LOADER;
                end else if (c_req && l_req) begin
                    pick = ~last_q;
                end else begin
                    pick = l_req;
                end
                if (c_req || l_req) begin
                    owner_d = pick;
                    we_d    = (pick == PORT_LOADER) ? l_we    : c_we;
                    addr_d  = (pick == PORT_LOADER) ? l_addr  : c_addr;
                    wdata_d = (pick == PORT_LOADER) ? l_wdata : c_wdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CW'(MEM_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Data is valid in the last WAIT cycle; capture on its closing edge
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    if (!we_q) begin
                        if (owner_q == PORT_LOADER) begin
                            l_rdata_d = m_rdata;
                        end else begin
                            c_rdata_d = m_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                last_d  = owner_q;
                if (owner_q == PORT_LOADER) begin
                    lock_d = lock_in;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        m_en_d    = (state_d == S_ISSUE);
        m_we_d    = (state_d == S_ISSUE) && we_d;
        c_ready_d = (state_d == S_RESP) && (owner_d == PORT_CORE);
        l_ready_d = (state_d == S_RESP) && (owner_d == PORT_LOADER);
        if (state_d == S_IDLE) begin
            grant_d = 2'b00;
        end else begin
            grant_d = (owner_d == PORT_LOADER) ? 2'b10 : 2'b01;
        end
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            owner_q <= PORT_CORE;
            last_q  <= PORT_LOADER;
            we_q    <= 1'b0;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            grant   <= 2'b00;
            c_ready <= 1'b0;
            l_ready <= 1'b0;
            c_rdata <= '0;
            l_rdata <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            m_en    <= m_en_d;
            m_we    <= m_we_d;
            m_addr  <= addr_d;
            m_wdata <= wdata_d;
            grant   <= grant_d;
            c_ready <= c_ready_d;
            l_ready <= l_ready_d;
            c_rdata <= c_rdata_d;
            l_rdata <= l_rdata_d;
        end
    end

endmodule
